// File: rtl/id_dispatch_queue_pkg.sv
// Shared definitions for the decode-to-dispatch queue: unit codes,
// reserved encodings and the default layout of a queued entry.
package id_pkg;

  localparam int UNIT_W_DEF    = 2;
  localparam int PAYLOAD_W_DEF = 128;
  localparam int TAG_W_DEF     = 5;

  // Execution unit codes; the all-ones code marks an undecodable instruction.
  typedef enum logic [UNIT_W_DEF-1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_LSU = 2'd2,
    UNIT_ERR = 2'd3
  } unit_e;

  // Lanes carrying this unit code are dropped at enqueue.
  localparam unit_e ERR_UNIT = UNIT_ERR;

  // Value of out_target while nothing has been dispatched since reset.
  localparam logic [TAG_W_DEF-1:0] TAG_INVALID = '1;

  // One queued instruction at the default widths; the queue stores the same
  // {unit, is_jump, payload} layout flattened to its parameterised width.
  typedef struct packed {
    unit_e                    unit;
    logic                     is_jump;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } dispatch_entry_t;

endpackage

// File: rtl/id_dispatch_queue_if.sv
// Decoder / ROB / reservation-station / ID-EX signals of the dispatch queue.
//
// Handshakes: decode lanes are taken on a rising edge when in_ready=1 and
// flush=0; in_ready depends only on registered occupancy, never on in_valid,
// so upstream holds its lanes while in_ready=0. On the dispatch side
// out_valid is a registered one-cycle strobe per dispatched entry; rob_alloc
// is high exactly in the cycle rob_avail_tag is consumed.
interface id_dispatch_queue_if #(
  parameter int DEPTH     = 8,
  parameter int ENQ_NUM   = 2,
  parameter int PAYLOAD_W = 128,
  parameter int UNIT_NUM  = 4,
  parameter int UNIT_W    = 2,
  parameter int TAG_W     = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                          flush;
  logic [ENQ_NUM-1:0]            in_valid;
  logic [ENQ_NUM*UNIT_W-1:0]     in_unit;
  logic [ENQ_NUM-1:0]            in_is_jump;
  logic [ENQ_NUM*PAYLOAD_W-1:0]  in_payload;
  logic                          in_ready;
  logic                          rob_full;
  logic [TAG_W-1:0]              rob_avail_tag;
  logic                          rob_alloc;
  logic [UNIT_NUM-1:0]           rs_full;
  logic                          jump_done;
  logic                          out_valid;
  logic [UNIT_W-1:0]             out_unit;
  logic                          out_is_jump;
  logic [PAYLOAD_W-1:0]          out_payload;
  logic [TAG_W-1:0]              out_target;
  logic [CNT_W-1:0]              count;
  logic                          jump_stall;
  logic                          full_stall;

  modport master (
    output flush, in_valid, in_unit, in_is_jump, in_payload,
    output rob_full, rob_avail_tag, rs_full, jump_done,
    input  in_ready, rob_alloc, out_valid, out_unit, out_is_jump,
    input  out_payload, out_target, count, jump_stall, full_stall
  );

  modport slave (
    input  flush, in_valid, in_unit, in_is_jump, in_payload,
    input  rob_full, rob_avail_tag, rs_full, jump_done,
    output in_ready, rob_alloc, out_valid, out_unit, out_is_jump,
    output out_payload, out_target, count, jump_stall, full_stall
  );
endinterface

// File: rtl/id_dispatch_queue_fifo.sv
// Multi-write, single-read circular store. Pointers carry one extra wrap bit
// so empty (equal) and full (low bits equal, MSB different) are distinct.
module dispatch_fifo #(
  parameter int DEPTH   = 8,
  parameter int ENQ_NUM = 2,
  parameter int W       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic [$clog2(ENQ_NUM+1)-1:0]     wr_num,
  input  logic [ENQ_NUM*W-1:0]             wr_data,
  input  logic                             rd_en,
  output logic [W-1:0]                     rd_data,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointer update: clear wins, otherwise advance by writes and the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
    end else begin
      tail <= tail + PTR_W'(wr_num);
      head <= head + PTR_W'(rd_en);
    end
  end

  // Storage: the first wr_num packed slots land at consecutive tail slots.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = 0; k < ENQ_NUM; k++) begin
        if (k < int'(wr_num)) begin
          mem[tail[AW-1:0] + AW'(k)] <= wr_data[k*W +: W];
        end
      end
    end
  end

  assign rd_data = mem[head[AW-1:0]];
  assign empty   = (head == tail);
  // Occupancy reaches DEPTH exactly when the pointers are in the full state.
  assign count   = CNT_W'(tail - head);
endmodule

// File: rtl/id_dispatch_queue.sv
// Decode-to-dispatch buffer: compacts valid decode lanes into the queue and
// issues at most one head entry per cycle, tagging each with a ROB tag.
import id_pkg::*;

module id_dispatch_queue #(
  parameter int DEPTH     = 8,
  parameter int ENQ_NUM   = 2,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int UNIT_NUM  = 4,
  parameter int UNIT_W    = UNIT_W_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  id_dispatch_queue_if.slave   bus
);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int NUM_W   = $clog2(ENQ_NUM + 1);
  localparam int ENTRY_W = UNIT_W + 1 + PAYLOAD_W;
  localparam logic [UNIT_W-1:0] ERR_CODE  = UNIT_W'(ERR_UNIT);
  localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(DEPTH - ENQ_NUM);

  logic [CNT_W-1:0]           count;
  logic                       empty;
  logic [ENTRY_W-1:0]         head_entry;
  logic [UNIT_W-1:0]          head_unit;
  logic                       head_jump;
  logic [PAYLOAD_W-1:0]       head_payload;
  logic [ENQ_NUM*ENTRY_W-1:0] wr_flat;
  logic [NUM_W-1:0]           wr_num;
  logic [UNIT_NUM-1:0]        rs_busy;
  logic                       in_ready;
  logic                       fire;

  logic                       out_valid_q;
  logic [UNIT_W-1:0]          out_unit_q;
  logic                       out_is_jump_q;
  logic [PAYLOAD_W-1:0]       out_payload_q;
  logic [TAG_W-1:0]           out_target_q;
  logic                       jump_stall_q;

  // Room for a whole lane group, judged from registered occupancy only.
  assign in_ready = (count <= READY_MAX);

  // Lane compaction: accepted lanes pack downward, error-unit lanes vanish.
  always_comb begin
    int unsigned acc;
    acc     = 0;
    wr_flat = '0;
    for (int i = 0; i < ENQ_NUM; i++) begin
      if (in_ready && !bus.flush && bus.in_valid[i] &&
          (bus.in_unit[i*UNIT_W +: UNIT_W] != ERR_CODE)) begin
        wr_flat[acc*ENTRY_W +: ENTRY_W] = {bus.in_unit[i*UNIT_W +: UNIT_W],
                                           bus.in_is_jump[i],
                                           bus.in_payload[i*PAYLOAD_W +: PAYLOAD_W]};
        acc = acc + 1;
      end
    end
    wr_num = NUM_W'(acc);
  end

  dispatch_fifo #(
    .DEPTH   (DEPTH),
    .ENQ_NUM (ENQ_NUM),
    .W       (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.flush),
    .wr_num  (wr_num),
    .wr_data (wr_flat),
    .rd_en   (fire),
    .rd_data (head_entry),
    .empty   (empty),
    .count   (count)
  );

  assign head_unit    = head_entry[ENTRY_W-1 -: UNIT_W];
  assign head_jump    = head_entry[PAYLOAD_W];
  assign head_payload = head_entry[PAYLOAD_W-1:0];
  assign rs_busy      = bus.rs_full;

  assign fire = !empty && !bus.rob_full && !rs_busy[head_unit] &&
                !jump_stall_q && !bus.flush;

  // Dispatch register and jump stall; flush clears both ahead of everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_unit_q    <= '0;
      out_is_jump_q <= 1'b0;
      out_payload_q <= '0;
      out_target_q  <= '1;
      jump_stall_q  <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      jump_stall_q <= 1'b0;
    end else begin
      out_valid_q <= fire;
      if (fire) begin
        out_unit_q    <= head_unit;
        out_is_jump_q <= head_jump;
        out_payload_q <= head_payload;
        out_target_q  <= bus.rob_avail_tag;
        if (head_jump) jump_stall_q <= 1'b1;
      end else if (bus.jump_done) begin
        jump_stall_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.rob_alloc   = fire;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_unit    = out_unit_q;
  assign bus.out_is_jump = out_is_jump_q;
  assign bus.out_payload = out_payload_q;
  assign bus.out_target  = out_target_q;
  assign bus.count       = count;
  assign bus.jump_stall  = jump_stall_q;
  assign bus.full_stall  = !empty && bus.rob_full;
endmodule

// File: doc/id_dispatch_queue.md
Name: id_dispatch_queue

Overview:
- Parametrised decode-to-dispatch buffer between the decoder and the ID/EX register.
- Accepts up to ENQ_NUM decoded instructions per cycle into an in-order circular queue.
- Dispatches at most one per cycle, allocating a ROB tag per dispatch. Dispatch is gated by ROB-full, per-unit reservation-full and an outstanding-jump stall.
- Adds multi-lane enqueue, queueing depth, explicit flush and jump-resolve handshakes on top of the single-instruction decode stage.

Parameters:
DEPTH, 8, queue entries; power of two, >= ENQ_NUM
ENQ_NUM, 2, decode lanes per cycle (1..4)
PAYLOAD_W, 128, packed decoded bundle (op, src tags/vals, pc, offset, width, rd)
UNIT_NUM, 4, execution units / reservation stations
UNIT_W, 2, width of unit code
TAG_W, 5, ROB tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  sync clear of queue and jump stall (mispredict / rst_tag)
in_valid  in  ENQ_NUM  per-lane decoded instruction valid
in_unit  in  ENQ_NUM*UNIT_W  per-lane target unit; lane i at [i*UNIT_W +: UNIT_W]
in_is_jump  in  ENQ_NUM  per-lane control-transfer flag
in_payload  in  ENQ_NUM*PAYLOAD_W  per-lane decoded bundle
in_ready  out  1  queue can accept ENQ_NUM entries this cycle
rob_full  in  1  ROB has no free tag
rob_avail_tag  in  TAG_W  next free ROB tag
rob_alloc  out  1  pulse; ROB consumes rob_avail_tag this cycle
rs_full  in  UNIT_NUM  per-unit reservation station full
jump_done  in  1  outstanding jump resolved
out_valid  out  1  dispatch valid to ID/EX
out_unit  out  UNIT_W  dispatched unit
out_is_jump  out  1  dispatched entry is a jump
out_payload  out  PAYLOAD_W  dispatched bundle
out_target  out  TAG_W  ROB tag assigned
count  out  $clog2(DEPTH+1)  occupied entries
jump_stall  out  1  jump outstanding
full_stall  out  1  head blocked by ROB full

Behaviour:
- Reset (async, rst=1), all outputs:
  - out_valid, out_unit, out_is_jump, out_payload, count, jump_stall: 0
  - out_target: TAG_INVALID
  - pointers: 0
  - in_ready: 1
  - rob_alloc, full_stall: 0
- Reset applied mid-operation discards all entries and any pending jump immediately; no partial dispatch.
- Pointers: head and tail are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Empty when equal; full when the low bits are equal and the MSBs differ.
- in_ready = (DEPTH - count) >= ENQ_NUM, decoded from registered count only. A same-cycle dequeue does not raise it.
- Enqueue, on a rising edge with in_ready=1 and flush=0:
  - Lanes are scanned 0..ENQ_NUM-1. Each lane with in_valid=1 and in_unit != ERR_UNIT is written at tail+k, where k = number of accepted lower lanes.
  - Gaps compact. Lanes with ERR_UNIT are dropped silently.
  - If in_ready=0, all lanes are ignored; upstream holds.
- Dispatch condition, evaluated on the head entry (combinational): fire = !empty && !rob_full && !rs_full[head.unit] && !jump_stall && !flush.
- rob_alloc = fire, in the same cycle that rob_avail_tag is sampled.
- On a fire edge:
  - out_valid<=1; out_* <= head fields; out_target <= rob_avail_tag; head++.
  - If head.is_jump, jump_stall<=1.
- On a non-fire edge: out_valid<=0. Other out_* hold their last value.
- Latency: an entry enqueued at edge N is at head at N+1 (if the queue was empty) and has out_valid at N+2 at the earliest.
- count_next = count + accepted - fire; simultaneous enqueue and dequeue are permitted.
- jump_stall:
  - Cleared by jump_done, or by flush, at the next edge.
  - jump_done while jump_stall=0 is ignored.
  - No dispatch occurs in the cycle jump_done is seen; it resumes the following cycle.
- full_stall = !empty && rob_full (combinational). rs_full blocking does not assert full_stall.
- Flush has priority over enqueue, dispatch and jump_done:
  - head=tail=0, count=0, jump_stall=0, out_valid<=0.
  - Same-cycle in_valid lanes are dropped; rob_alloc=0.

Decomposition:
- Shared package id_pkg: TAG_INVALID (all ones), ERR_UNIT unit code, the dispatch_entry_t struct (unit, is_jump, payload), and the unit code enum.
- Sub-module dispatch_fifo: multi-write, single-read circular storage with pointers and count.
- id_dispatch_queue keeps lane compaction, the fire logic, the jump stall flop and the output register.

Test Plan:
- Reset then enqueue 2 lanes (unit 1, unit 2), rob_avail_tag=3 then 4, no stalls -> out_valid at cycles 2 and 3, targets 3 and 4, count back to 0, rob_alloc pulsed twice.
- Lane0 invalid, lane1 valid; plus a lane with ERR_UNIT -> only the valid non-error lane is stored, at the old tail; count +1.
- Fill to 7 of DEPTH=8 -> in_ready=0; then dispatch 1 -> in_ready=1 the next cycle; pointers wrap past 8 without loss or reorder across 20 entries.
- rob_full=1 with 3 entries queued -> full_stall=1, no rob_alloc, out_valid=0; release -> dispatch resumes in order. rs_full[head.unit]=1 -> blocked with full_stall=0.
- Dispatch a jump followed by 2 queued entries -> jump_stall=1, no dispatch; jump_done pulse -> next dispatch one cycle later.
- Flush with 5 entries queued, a jump pending and lanes valid the same cycle -> count=0, jump_stall=0, out_valid=0 next cycle; asserting rst mid-dispatch -> all outputs at reset values immediately.
